// File: rtl/inst_encoder_i_pkg.sv
// Shared types and encoding constants for the I-type instruction encoder.
// OP_LI is a pseudo-op that expands to LUI/ORI (or one word with INST_ENCODER_LI_SHORT_EN).
package inst_encoder_i_pkg;

  typedef logic [4:0]  RegAddr_t;
  typedef logic [31:0] Inst_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_JR,
    OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_LW, OP_SW,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_TEQI,
    OP_LI
  } Oper_t;

  localparam logic [5:0] OPC_REGIMM = 6'b000001;
  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_BNE    = 6'b000101;
  localparam logic [5:0] OPC_BLEZ   = 6'b000110;
  localparam logic [5:0] OPC_BGTZ   = 6'b000111;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_ADDIU  = 6'b001001;
  localparam logic [5:0] OPC_SLTI   = 6'b001010;
  localparam logic [5:0] OPC_SLTIU  = 6'b001011;
  localparam logic [5:0] OPC_ANDI   = 6'b001100;
  localparam logic [5:0] OPC_ORI    = 6'b001101;
  localparam logic [5:0] OPC_XORI   = 6'b001110;
  localparam logic [5:0] OPC_LUI    = 6'b001111;
  localparam logic [5:0] OPC_LW     = 6'b100011;
  localparam logic [5:0] OPC_SW     = 6'b101011;

  localparam logic [4:0] REGIMM_BLTZ   = 5'b00000;
  localparam logic [4:0] REGIMM_BGEZ   = 5'b00001;
  localparam logic [4:0] REGIMM_BLTZAL = 5'b10000;
  localparam logic [4:0] REGIMM_BGEZAL = 5'b10001;
  localparam logic [4:0] REGIMM_TEQI   = 5'b01100;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    EMIT_HI
  } EncState_t;

  function automatic Inst_t make_i(input logic [5:0] opc, input RegAddr_t rs,
                                   input RegAddr_t rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_encoder_i_pack.sv
// Combinational I-type packer: maps one real operation onto its 32-bit word.
// supported is low for any op that has no I-type encoding (R-type ops, OP_LI).
module inst_i_pack
  import inst_encoder_i_pkg::*;
(
  input  Oper_t       op,
  input  RegAddr_t    rs,
  input  RegAddr_t    rt,
  input  logic [15:0] imm16,
  output Inst_t       word,
  output logic        supported
);

  logic [5:0] opc;
  RegAddr_t   rs_f;
  RegAddr_t   rt_f;

  // Fields forced to zero (LUI rs, BLEZ/BGTZ rt) or replaced (REGIMM rt code) here.
  always_comb begin
    opc       = 6'b000000;
    rs_f      = rs;
    rt_f      = rt;
    supported = 1'b1;
    case (op)
      OP_ANDI:   opc = OPC_ANDI;
      OP_ORI:    opc = OPC_ORI;
      OP_XORI:   opc = OPC_XORI;
      OP_LUI:    begin opc = OPC_LUI;    rs_f = '0; end
      OP_ADDI:   opc = OPC_ADDI;
      OP_ADDIU:  opc = OPC_ADDIU;
      OP_SLTI:   opc = OPC_SLTI;
      OP_SLTIU:  opc = OPC_SLTIU;
      OP_BEQ:    opc = OPC_BEQ;
      OP_BNE:    opc = OPC_BNE;
      OP_BLEZ:   begin opc = OPC_BLEZ;   rt_f = '0; end
      OP_BGTZ:   begin opc = OPC_BGTZ;   rt_f = '0; end
      OP_LW:     opc = OPC_LW;
      OP_SW:     opc = OPC_SW;
      OP_BLTZ:   begin opc = OPC_REGIMM; rt_f = REGIMM_BLTZ;   end
      OP_BGEZ:   begin opc = OPC_REGIMM; rt_f = REGIMM_BGEZ;   end
      OP_BLTZAL: begin opc = OPC_REGIMM; rt_f = REGIMM_BLTZAL; end
      OP_BGEZAL: begin opc = OPC_REGIMM; rt_f = REGIMM_BGEZAL; end
      OP_TEQI:   begin opc = OPC_REGIMM; rt_f = REGIMM_TEQI;   end
      default: begin
        supported = 1'b0;
        rs_f      = '0;
        rt_f      = '0;
      end
    endcase
    word = make_i(opc, rs_f, rt_f, imm16);
  end

endmodule

// File: rtl/inst_encoder_i.sv
// Streaming I-type instruction encoder with valid/ready on both sides and a registered output.
// Define INST_ENCODER_LI_SHORT_EN to let OP_LI collapse to one word when either half is zero.
module inst_encoder_i
  import inst_encoder_i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  Oper_t       req_op,
  input  RegAddr_t    req_rs,
  input  RegAddr_t    req_rt,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output Inst_t       inst,
  output logic        enc_err
);

  EncState_t   state_q, state_d;
  Inst_t       inst_q, inst_d;
  logic        enc_err_q, enc_err_d;
  RegAddr_t    li_rt_q, li_rt_d;
  logic [15:0] li_lo_q, li_lo_d;

  Oper_t       pk_op;
  RegAddr_t    pk_rs;
  RegAddr_t    pk_rt;
  logic [15:0] pk_imm;
  Inst_t       pk_word;
  logic        pk_supported;
  logic        li_two;
  logic        accept;

  assign req_ready  = (state_q == IDLE) || ((state_q == EMIT) && inst_ready);
  assign accept     = req_valid && req_ready;
  assign inst_valid = (state_q != IDLE);
  assign inst       = inst_q;
  assign enc_err    = enc_err_q;

  // The packer is shared: in EMIT_HI it builds the pending ORI, otherwise the incoming request.
  always_comb begin
    pk_op  = req_op;
    pk_rs  = req_rs;
    pk_rt  = req_rt;
    pk_imm = req_imm[15:0];
    li_two = 1'b1;
    if (state_q == EMIT_HI) begin
      pk_op  = OP_ORI;
      pk_rs  = li_rt_q;
      pk_rt  = li_rt_q;
      pk_imm = li_lo_q;
    end else if (req_op == OP_LI) begin
      pk_op  = OP_LUI;
      pk_imm = req_imm[31:16];
`ifdef INST_ENCODER_LI_SHORT_EN
      if (req_imm[31:16] == 16'h0000) begin
        pk_op  = OP_ORI;
        pk_rs  = '0;
        pk_imm = req_imm[15:0];
        li_two = 1'b0;
      end else if (req_imm[15:0] == 16'h0000) begin
        li_two = 1'b0;
      end
`endif
    end
  end

  inst_i_pack u_pack (
    .op        (pk_op),
    .rs        (pk_rs),
    .rt        (pk_rt),
    .imm16     (pk_imm),
    .word      (pk_word),
    .supported (pk_supported)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    enc_err_d = 1'b0;
    li_rt_d   = li_rt_q;
    li_lo_d   = li_lo_q;
    case (state_q)
      EMIT_HI: if (inst_ready) begin
        inst_d  = pk_word;
        state_d = EMIT;
      end
      EMIT: if (inst_ready) state_d = IDLE;
      default: ;
    endcase
    // A new request overrides the retire-to-IDLE decision above.
    if (accept) begin
      if (req_op == OP_LI) begin
        inst_d  = pk_word;
        state_d = li_two ? EMIT_HI : EMIT;
        li_rt_d = req_rt;
        li_lo_d = req_imm[15:0];
      end else if (pk_supported) begin
        inst_d  = pk_word;
        state_d = EMIT;
      end else begin
        enc_err_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      enc_err_q <= 1'b0;
      li_rt_q   <= '0;
      li_lo_q   <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      enc_err_q <= enc_err_d;
      li_rt_q   <= li_rt_d;
      li_lo_q   <= li_lo_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder_i.sv
// Bench for inst_encoder_i: directed test-plan steps, then random traffic against a word-queue model.
module tb_inst_encoder_i;
  import inst_encoder_i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  Oper_t       req_op = OP_ADD;
  RegAddr_t    req_rs = '0;
  RegAddr_t    req_rt = '0;
  logic [31:0] req_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  Inst_t       inst;
  logic        enc_err;

  int    checks = 0;
  int    errors = 0;
  Inst_t exp_q[$];
  logic  exp_err = 1'b0;

  always #5 clk = ~clk;

  inst_encoder_i dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_imm    (req_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .enc_err    (enc_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Words an op should produce, straight from the instruction-format table.
  function automatic int expand(input Oper_t op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] imm, output Inst_t w0, output Inst_t w1);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = imm[15:0];
    hi = imm[31:16];
    w0 = '0;
    w1 = '0;
    case (op)
      OP_ANDI:   begin w0 = {6'b001100, rs, rt, lo}; return 1; end
      OP_ORI:    begin w0 = {6'b001101, rs, rt, lo}; return 1; end
      OP_XORI:   begin w0 = {6'b001110, rs, rt, lo}; return 1; end
      OP_LUI:    begin w0 = {6'b001111, 5'd0, rt, lo}; return 1; end
      OP_ADDI:   begin w0 = {6'b001000, rs, rt, lo}; return 1; end
      OP_ADDIU:  begin w0 = {6'b001001, rs, rt, lo}; return 1; end
      OP_SLTI:   begin w0 = {6'b001010, rs, rt, lo}; return 1; end
      OP_SLTIU:  begin w0 = {6'b001011, rs, rt, lo}; return 1; end
      OP_BEQ:    begin w0 = {6'b000100, rs, rt, lo}; return 1; end
      OP_BNE:    begin w0 = {6'b000101, rs, rt, lo}; return 1; end
      OP_BLEZ:   begin w0 = {6'b000110, rs, 5'd0, lo}; return 1; end
      OP_BGTZ:   begin w0 = {6'b000111, rs, 5'd0, lo}; return 1; end
      OP_LW:     begin w0 = {6'b100011, rs, rt, lo}; return 1; end
      OP_SW:     begin w0 = {6'b101011, rs, rt, lo}; return 1; end
      OP_BLTZ:   begin w0 = {6'b000001, rs, 5'b00000, lo}; return 1; end
      OP_BGEZ:   begin w0 = {6'b000001, rs, 5'b00001, lo}; return 1; end
      OP_BLTZAL: begin w0 = {6'b000001, rs, 5'b10000, lo}; return 1; end
      OP_BGEZAL: begin w0 = {6'b000001, rs, 5'b10001, lo}; return 1; end
      OP_TEQI:   begin w0 = {6'b000001, rs, 5'b01100, lo}; return 1; end
      OP_LI: begin
`ifdef INST_ENCODER_LI_SHORT_EN
        if (hi == 16'h0000) begin w0 = {6'b001101, 5'd0, rt, lo}; return 1; end
        if (lo == 16'h0000) begin w0 = {6'b001111, 5'd0, rt, hi}; return 1; end
`endif
        w0 = {6'b001111, 5'd0, rt, hi};
        w1 = {6'b001101, rt, rt, lo};
        return 2;
      end
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive, check mid-cycle against the model, advance the model, cross the edge.
  task automatic step(input logic v, input Oper_t op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [31:0] imm, input logic rdy, input logic r);
    Inst_t w0, w1;
    int    n;
    logic  exp_ready;
    logic  consume;
    req_valid  = v;
    req_op     = op;
    req_rs     = rs;
    req_rt     = rt;
    req_imm    = imm;
    inst_ready = rdy;
    rst        = r;
    #4;
    exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && rdy);
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    check("enc_err", {31'd0, enc_err}, {31'd0, exp_err});
    if (exp_q.size() != 0) check("inst", inst, exp_q[0]);
    consume = (exp_q.size() != 0) && rdy;
    exp_err = 1'b0;
    if (r) begin
      exp_q.delete();
    end else begin
      if (consume) void'(exp_q.pop_front());
      if (v && exp_ready) begin
        n = expand(op, rs, rt, imm, w0, w1);
        if (n == 0) exp_err = 1'b1;
        if (n >= 1) exp_q.push_back(w0);
        if (n == 2) exp_q.push_back(w1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    Oper_t       rop;
    logic [31:0] rimm;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    check("reset inst", inst, 32'd0);
    check("reset enc_err", {31'd0, enc_err}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    step(1'b1, OP_ADDIU, 5'd1, 5'd2, 32'h0000_0010, 1'b1, 1'b0);
    check("addiu word", inst, 32'h2422_0010);
    check("addiu err", {31'd0, enc_err}, 32'd0);
    idle(2);

    step(1'b1, OP_LI, 5'd0, 5'd8, 32'h1234_5678, 1'b1, 1'b0);
    check("li hi word", inst, 32'h3C08_1234);
    check("li hi req_ready", {31'd0, req_ready}, 32'd0);
    step(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("li lo word", inst, 32'h3508_5678);
    idle(2);

    step(1'b1, OP_LI, 5'd0, 5'd8, 32'h0000_5678, 1'b1, 1'b0);
`ifdef INST_ENCODER_LI_SHORT_EN
    check("li short lo", inst, 32'h3408_5678);
`else
    check("li full lo-only hi word", inst, 32'h3C08_0000);
`endif
    idle(3);
    step(1'b1, OP_LI, 5'd0, 5'd8, 32'h1234_0000, 1'b1, 1'b0);
    check("li hi-only first word", inst, 32'h3C08_1234);
    idle(3);

    step(1'b1, OP_BGEZAL, 5'd3, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, OP_ADDI, 5'd1, 5'd1, 32'd1, 1'b0, 1'b0);
      check("bgezal hold", inst, 32'h0471_FFFF);
    end
    idle(2);

    step(1'b1, OP_ADD, 5'd1, 5'd2, 32'd3, 1'b1, 1'b0);
    check("bad op err", {31'd0, enc_err}, 32'd1);
    check("bad op valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, OP_BEQ, 5'd4, 5'd5, 32'h0000_0003, 1'b1, 1'b0);
    check("beq err clear", {31'd0, enc_err}, 32'd0);
    check("beq word", inst, 32'h1085_0003);
    idle(2);

    step(1'b1, OP_LI, 5'd0, 5'd8, 32'h1234_5678, 1'b1, 1'b0);
    step(1'b0, OP_ADD, 5'd0, 5'd0, 32'd0, 1'b1, 1'b1);
    check("rst valid", {31'd0, inst_valid}, 32'd0);
    check("rst ready", {31'd0, req_ready}, 32'd1);
    check("rst inst", inst, 32'd0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      rop  = Oper_t'(5'($urandom_range(0, 25)));
      rimm = $urandom;
      case ($urandom_range(0, 3))
        0: rimm[31:16] = 16'h0000;
        1: rimm[15:0]  = 16'h0000;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, rop, 5'($urandom), 5'($urandom), rimm,
           $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
